// File: rtl/uart_led_tx_if.sv
// Push handshake between the CPU LED port and the UART output stage.
// The master drives a byte with a one-cycle valid strobe; the slave reports ready (FIFO has room).
interface uart_led_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_led_tx.sv
// LED byte buffer feeding an 8N1 LSB-first UART transmitter.
// Pushes that arrive while the FIFO is full are dropped and latch a sticky overflow flag.
module uart_led_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_led_tx_if.slave                cpu,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0]  DepthC   = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q;
  logic            do_push, do_pop;

  state_e          state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            baud_last;

  // No bypass: readiness depends only on the registered occupancy.
  assign cpu.ready = (count_q < DepthC);
  assign do_push   = cpu.valid & cpu.ready;
  assign count_d   = count_q + CntW'(do_push) - CntW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= cpu.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      if (cpu.valid && !cpu.ready) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    do_pop    = 1'b0;
    tx_d      = 1'b1;
    baud_last = (baud_q == BaudLast);

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          do_pop  = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back: the next frame's start bit follows the stop bit with no idle gap.
          if (count_q != '0) begin
            do_pop  = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered line value reflects the state being entered on this edge.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/uart_led_tx.md
Name: uart_led_tx

Overview:
- Downstream output stage for the mini CPU's LED port. It captures each byte the CPU writes on an LED instruction and buffers it in a small FIFO.
- It serialises buffered bytes onto a single UART TX line, 8N1 framing, LSB first.
- The CPU sees a ready/valid-style push interface. Overflow is detected and flagged; it never stalls the CPU.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range >= 2 (434 for 50 MHz / 115200 on board).
- FIFO_DEPTH, 4, byte entries; power of two, >= 2.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- iData  input  8  byte to transmit; the CPU's LED source data.
- iValid  input  1  push strobe; the CPU's LED write enable, one cycle per byte.
- oReady  output  1  1 = FIFO not full; a push is accepted this cycle.
- oTx  output  1  UART serial line; idles high.
- oBusy  output  1  1 = FSM not in IDLE, or FIFO not empty.
- oFifoCount  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- oOverflow  output  1  sticky; set when iValid=1 while oReady=0.

Behaviour:
- Reset (Reset=0, asynchronous):
  - oTx=1, oBusy=0, oFifoCount=0, oOverflow=0, oReady=1.
  - FIFO pointers cleared; FSM forced to IDLE; baud counter and bit index cleared.
  - Reset mid-frame aborts the frame: oTx returns to 1 immediately, and all buffered bytes are discarded.
- FIFO:
  - A push occurs on an edge where iValid=1 and oReady=1.
  - oReady is combinational from occupancy: count < FIFO_DEPTH. There is no same-cycle bypass, so a pop on the same edge does not make room for a push while full.
  - Push and pop on the same edge leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - iValid=1 while full: the byte is dropped and oOverflow is set to 1 on that edge. It stays 1 until reset.
- FSM states: IDLE, START, DATA, STOP. oTx is registered.
  - IDLE: oTx=1. If the FIFO is non-empty, on that edge pop the head into the shift register, clear the baud counter, go to START.
  - START: oTx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: oTx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: oTx=1 for CLKS_PER_BIT cycles. At the final stop-bit cycle:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap);
    - else go to IDLE.
- Timing:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps; it is $clog2(CLKS_PER_BIT) bits wide.
  - Latency: a byte pushed into an empty FIFO with FSM in IDLE at edge E0 is popped at E1. oTx falls to 0 after E1.
  - One frame = 10*CLKS_PER_BIT cycles. Back-to-back frames are exactly 10*CLKS_PER_BIT apart.
- oBusy is combinational: (state != IDLE) or (count != 0).

Test Plan:
- Single byte: CLKS_PER_BIT=4, push 0xA5 at E0 -> oTx=1 through E0, then from E1 the bits 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles. oBusy drops to 0 after cycle E1+40. oOverflow=0.
- Back-to-back: push 0x00 at E0 and 0xFF at E1 -> oTx low for 36 cycles (start + 8 data bits), then stop high for 4 cycles. Immediately followed by a 4-cycle start 0, then 36 cycles of 1 (data + stop). Total 80 cycles from E1, with no extra idle cycle between frames.
- Overflow: FIFO_DEPTH=4, push bytes 0x01..0x06 on consecutive edges E0..E5:
  - 0x01 is popped at E1; oFifoCount reaches 4 after E4; oReady=0 at E5.
  - 0x06 is dropped and oOverflow=1 from E5.
  - Line carries 0x01..0x05 in order; oOverflow stays 1 afterwards.
- Full boundary: with FIFO full and a pop occurring at the STOP-to-START edge, assert iValid on that edge -> push rejected (oReady=0), oOverflow=1, oFifoCount goes 4 to 3.
- Reset mid-frame: push 0x3C and 0x55, then assert Reset low for 1 cycle during DATA bit 3 -> oTx=1 immediately, oFifoCount=0, oBusy=0, oOverflow=0. No further frames after release. A subsequent push of 0x81 transmits correctly.
- Idle stability: no pushes for 1000 cycles after reset -> oTx constant 1, oBusy=0, oReady=1.
